// File: rtl/bus_grant_scheduler_if.sv
// Request/grant bundle between the requesting units and bus_grant_scheduler.
// master = requester side, slave = scheduler side.
interface bus_grant_scheduler_if;
    logic       arb_en;
    logic [7:0] req;
    logic [2:0] sel;
    logic       grant_valid;
    logic       timeout;

    modport master (
        output arb_en,
        output req,
        input  sel,
        input  grant_valid,
        input  timeout
    );

    modport slave (
        input  arb_en,
        input  req,
        output sel,
        output grant_valid,
        output timeout
    );
endinterface

// File: rtl/bus_grant_scheduler.sv
// Eight-way round-robin scheduler driving a 3-to-8 decoder select with a grant qualifier.
// Optional hold limit with a one-cycle timeout pulse is enabled by defining ARB_TIMEOUT_EN.
module bus_grant_scheduler #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    bus_grant_scheduler_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [2:0] sel_r;
    logic [2:0] sel_s;
    logic       grant_valid_r;
    logic       grant_valid_s;
    logic [2:0] last_ptr_r;
    logic [2:0] last_ptr_s;
    logic [2:0] winner_s;
    logic       any_req_s;

`ifdef ARB_TIMEOUT_EN
    logic             timeout_r;
    logic             timeout_s;
    logic [CNT_W-1:0] hold_cnt_r;
    logic [CNT_W-1:0] hold_cnt_s;
`endif

    if ((MAX_HOLD < 1) || (MAX_HOLD > 255) || ((2 ** CNT_W) <= MAX_HOLD)) begin : g_bad_param
        $error("bus_grant_scheduler: illegal MAX_HOLD/CNT_W combination");
    end

    // Search starts just past the last owner, so the previous owner is always tried last.
    function automatic logic [2:0] rr_pick(input logic [7:0] req_v, input logic [2:0] ptr);
        logic [2:0] idx;
        logic [2:0] pick;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && req_v[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Arbitration inputs derived from the sampled request vector.
    always_comb begin
        any_req_s = |bus.req;
        winner_s  = rr_pick(bus.req, last_ptr_r);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s       = state_r;
        sel_s         = sel_r;
        grant_valid_s = 1'b0;
        last_ptr_s    = last_ptr_r;
`ifdef ARB_TIMEOUT_EN
        timeout_s     = 1'b0;
        hold_cnt_s    = hold_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (bus.arb_en && any_req_s) begin
                    state_s       = GRANT;
                    sel_s         = winner_s;
                    grant_valid_s = 1'b1;
                    last_ptr_s    = winner_s;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_s    = {CNT_W{1'b0}};
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                // arb_en is deliberately ignored here: only the owner ends its grant.
                if (!bus.req[sel_r]) begin
                    state_s = IDLE;
`ifdef ARB_TIMEOUT_EN
                end else if (hold_cnt_r == CNT_W'(MAX_HOLD - 1)) begin
                    state_s   = IDLE;
                    timeout_s = 1'b1;
`endif
                end else begin
                    state_s       = GRANT;
                    grant_valid_s = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    if (hold_cnt_r != {CNT_W{1'b1}}) begin
                        hold_cnt_s = hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        hold_cnt_s = hold_cnt_r;
                    end
`endif
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered outputs; last_ptr resets to 7 so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            sel_r         <= 3'd0;
            grant_valid_r <= 1'b0;
            last_ptr_r    <= 3'd7;
`ifdef ARB_TIMEOUT_EN
            timeout_r     <= 1'b0;
            hold_cnt_r    <= {CNT_W{1'b0}};
`endif
        end else begin
            state_r       <= state_s;
            sel_r         <= sel_s;
            grant_valid_r <= grant_valid_s;
            last_ptr_r    <= last_ptr_s;
`ifdef ARB_TIMEOUT_EN
            timeout_r     <= timeout_s;
            hold_cnt_r    <= hold_cnt_s;
`endif
        end
    end

    assign bus.sel         = sel_r;
    assign bus.grant_valid = grant_valid_r;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout     = timeout_r;
`else
    assign bus.timeout     = 1'b0;
`endif

endmodule
